// File: rtl/niosii_leds_blink.sv
// niosii_leds_blink: memory-mapped LED register block with per-channel blinking driven by a reloadable down-counter.
module niosii_leds_blink #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(8'h55),
    parameter int unsigned           PRESCALE_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [WIDTH-1:0]         out_port
);
    logic [WIDTH-1:0]      data_q, data_d, blink_q, blink_d;
    logic [PRESCALE_W-1:0] period_q, period_d, cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  wr;
    logic [WIDTH-1:0]      wd;
    logic [PRESCALE_W-1:0] wp;

    assign wr = chipselect && !write_n;
    assign wd = writedata[WIDTH-1:0];
    assign wp = writedata[PRESCALE_W-1:0];

    always_comb begin
        data_d   = data_q;
        blink_d  = blink_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (wr) begin
            data_d   = address == 3'd0 ? wd :
                       address == 3'd3 ? (data_q | wd) :
                       address == 3'd4 ? (data_q & ~wd) : data_q;
            blink_d  = address == 3'd1 ? wd : blink_q;
            period_d = address == 3'd2 ? wp : period_q;
        end
        // A PERIOD write restarts the blink cycle and wins over that cycle's expiry.
        if (wr && address == 3'd2) begin
            cnt_d   = wp;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            blink_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            data_q   <= data_d;
            blink_q  <= blink_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        readdata = address == 3'd0 ? 32'(data_q) :
                   address == 3'd1 ? 32'(blink_q) :
                   address == 3'd2 ? 32'(period_q) :
                   address == 3'd5 ? 32'(phase_q) : 32'd0;
    end

    assign out_port = data_q & ~(blink_q & {WIDTH{~phase_q}});
endmodule
